booth_mult_seq: RTL and testbench

Parametrised sequential radix-2 Booth multiplier with signed/unsigned mode select, start/busy/done handshake and an iteration counter for debug. It generalises the fixed 4-bit Booth multiplier to any operand width. It adds unsigned operation, a completion pulse and a held result register. It sits as a standalone arithmetic unit behind a simple controller or testbench driving `start`.

---
 rtl/booth_pkg.sv | 20 ++
 rtl/booth_step.sv | 37 +++
 rtl/booth_mult_seq.sv | 130 +++++++++++++
 tb/tb_booth_mult_seq.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// Shared types and width helpers for the sequential radix-2 Booth multiplier.
// Extended operands carry one guard bit; the accumulator carries two.
package booth_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } booth_state_t;

    // Operand width after sign/zero extension (one guard bit for unsigned mode)
    function automatic int ext_w(input int width);
        return width + 1;
    endfunction

    // Accumulator width: one more bit again so A - M cannot overflow for M = -2^(WIDTH-1)
    function automatic int acc_w(input int width);
        return width + 2;
    endfunction

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: add/subtract the multiplicand according to
// {Q[0], Q-1}, then arithmetic right shift of {A, Q, Q-1}. Purely combinational.
module booth_step
    import booth_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic signed [acc_w(WIDTH)-1:0] a_i,
    input  logic        [ext_w(WIDTH)-1:0] q_i,
    input  logic                           qm1_i,
    input  logic signed [ext_w(WIDTH)-1:0] ext_m_i,
    output logic signed [acc_w(WIDTH)-1:0] a_o,
    output logic        [ext_w(WIDTH)-1:0] q_o,
    output logic                           qm1_o
);

    localparam int EW = ext_w(WIDTH);
    localparam int AW = acc_w(WIDTH);

    logic signed [AW-1:0] m_sext;
    logic signed [AW-1:0] sum;

    assign m_sext = {ext_m_i[EW-1], ext_m_i};

    always_comb begin
        sum = a_i;
        unique case ({q_i[0], qm1_i})
            2'b01:   sum = a_i + m_sext;
            2'b10:   sum = a_i - m_sext;
            default: sum = a_i;
        endcase
    end

    // Arithmetic shift: replicate the accumulator sign into the vacated MSB
    assign {a_o, q_o, qm1_o} = {sum[AW-1], sum, q_i};

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier, signed or unsigned, WIDTH+1 cycles per
// product, with start/busy/done handshake, held result and iteration counter.
module booth_mult_seq
    import booth_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CW    = $clog2(WIDTH + 2)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy,
    output logic                 done,
    output logic [CW-1:0]        count
);

    localparam int EW = ext_w(WIDTH);
    localparam int AW = acc_w(WIDTH);
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH);

    booth_state_t state_q, state_d;

    logic signed [AW-1:0]  a_q,   a_d;
    logic        [EW-1:0]  q_q,   q_d;
    logic                  qm1_q, qm1_d;
    logic signed [EW-1:0]  m_q,   m_d;
    logic [CW-1:0]         count_q,   count_d;
    logic [2*WIDTH-1:0]    product_q, product_d;
    logic                  busy_q,    busy_d;
    logic                  done_q,    done_d;

    logic signed [AW-1:0]  step_a;
    logic        [EW-1:0]  step_q;
    logic                  step_qm1;

    logic [EW-1:0]         ext_mcand;
    logic [EW-1:0]         ext_mplier;

    // Guard bit is the operand sign in signed mode, zero otherwise
    assign ext_mcand  = signed_mode ? {multiplicand[WIDTH-1], multiplicand}
                                    : {1'b0, multiplicand};
    assign ext_mplier = signed_mode ? {multiplier[WIDTH-1], multiplier}
                                    : {1'b0, multiplier};

    booth_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .a_i     (a_q),
        .q_i     (q_q),
        .qm1_i   (qm1_q),
        .ext_m_i (m_q),
        .a_o     (step_a),
        .q_o     (step_q),
        .qm1_o   (step_qm1)
    );

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        q_d       = q_q;
        qm1_d     = qm1_q;
        m_d       = m_q;
        count_d   = count_q;
        product_d = product_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    m_d     = ext_mcand;
                    q_d     = ext_mplier;
                    a_d     = '0;
                    qm1_d   = 1'b0;
                    count_d = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d     = step_a;
                q_d     = step_q;
                qm1_d   = step_qm1;
                count_d = count_q + CW'(1);
                // Final iteration: the low 2*WIDTH bits of {A, Q} hold the product
                if (count_q == LAST_ITER) begin
                    product_d = {step_a[WIDTH-2:0], step_q};
                    done_d    = 1'b1;
                    busy_d    = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            a_q       <= '0;
            q_q       <= '0;
            qm1_q     <= 1'b0;
            m_q       <= '0;
            count_q   <= '0;
            product_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            q_q       <= q_d;
            qm1_q     <= qm1_d;
            m_q       <= m_d;
            count_q   <= count_d;
            product_q <= product_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign product = product_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign count   = count_q;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Scoreboard bench for booth_mult_seq: accepted requests push the arithmetic
// product, a monitor pops and compares on every done pulse.
module tb_booth_mult_seq;

    localparam int W  = 4;
    localparam int CW = $clog2(W + 2);
    localparam int PW = 2 * W;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          signed_mode;
    logic [W-1:0]  multiplicand;
    logic [W-1:0]  multiplier;
    logic [PW-1:0] product;
    logic          busy;
    logic          done;
    logic [CW-1:0] count;

    booth_mult_seq #(
        .WIDTH (W),
        .CW    (CW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .signed_mode  (signed_mode),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .product      (product),
        .busy         (busy),
        .done         (done),
        .count        (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [PW-1:0] prod;
        int            acc_cyc;
    } exp_t;

    exp_t          sb_q[$];
    int            n_checks = 0;
    int            n_fail   = 0;
    int            cyc      = 0;
    logic [PW-1:0] last_prod = '0;

    function automatic logic [PW-1:0] ref_mul(input logic [W-1:0] a,
                                              input logic [W-1:0] b,
                                              input logic s);
        longint x, y;
        x = s ? longint'($signed(a)) : longint'(a);
        y = s ? longint'($signed(b)) : longint'(b);
        return PW'(x * y);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Request side: an accepted start is one seen while the unit is idle
    always @(posedge clk) begin
        exp_t e;
        cyc++;
        if (rst_n && start && !busy) begin
            e.prod    = ref_mul(multiplicand, multiplier, signed_mode);
            e.acc_cyc = cyc;
            sb_q.push_back(e);
        end
    end

    // Response side
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (rst_n) begin
            if (done) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done=1, expected no pending request (t=%0t)", $time);
                end else begin
                    e = sb_q.pop_front();
                    check("product", product, e.prod);
                    check("latency", cyc - e.acc_cyc, W + 1);
                    check("count_at_done", count, W + 1);
                    last_prod = e.prod;
                end
            end else begin
                check("product_hold", product, last_prod);
            end
            check("busy", busy, sb_q.size() != 0);
        end
    end

    task automatic wait_done(input string name);
        int k = 0;
        while (!done && k < 20) begin
            @(negedge clk);
            k++;
        end
        check({name, "_done_seen"}, done, 1'b1);
    endtask

    task automatic directed(input string name, input logic s, input logic [W-1:0] a,
                            input logic [W-1:0] b, input logic [PW-1:0] expv);
        @(negedge clk);
        signed_mode  = s;
        multiplicand = a;
        multiplier   = b;
        start        = 1'b1;
        @(negedge clk);
        start        = 1'b0;
        signed_mode  = ~s;
        multiplicand = W'($urandom);
        multiplier   = W'($urandom);
        wait_done(name);
        check({name, "_product"}, product, expv);
        check({name, "_count"}, count, W + 1);
        check({name, "_busy_low"}, busy, 1'b0);
    endtask

    task automatic drain();
        int k = 0;
        while ((sb_q.size() != 0 || busy) && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("drain_pending", sb_q.size(), 0);
    endtask

    initial begin
        rst_n        = 1'b0;
        start        = 1'b0;
        signed_mode  = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_product", product, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_count", count, 0);
        @(negedge clk);
        rst_n = 1'b1;

        directed("u3x2", 1'b0, 4'd3, 4'd2, 8'd6);
        directed("s_m8xm8", 1'b1, 4'h8, 4'h8, 8'h40);
        directed("s_m3x5", 1'b1, 4'hD, 4'h5, 8'hF1);
        directed("u15x15", 1'b0, 4'hF, 4'hF, 8'hE1);

        // Random single requests with noisy inputs; some starts land while busy
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            signed_mode  = 1'($urandom);
            multiplicand = W'($urandom);
            multiplier   = W'($urandom);
            start        = 1'b1;
            @(negedge clk);
            start = 1'b0;
            repeat ($urandom_range(0, 7)) begin
                signed_mode  = 1'($urandom);
                multiplicand = W'($urandom);
                multiplier   = W'($urandom);
                start        = 1'($urandom_range(0, 3) == 0);
                @(negedge clk);
            end
            start = 1'b0;
        end
        drain();

        // start held high, operands changing every cycle
        @(negedge clk);
        start = 1'b1;
        repeat (40) begin
            signed_mode  = 1'($urandom);
            multiplicand = W'($urandom);
            multiplier   = W'($urandom);
            @(negedge clk);
        end
        start = 1'b0;
        drain();

        // Reset during iteration 3 of 7x7 unsigned
        @(negedge clk);
        signed_mode  = 1'b0;
        multiplicand = 4'd7;
        multiplier   = 4'd7;
        start        = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("mid_run_count", count, 2);
        check("mid_run_busy", busy, 1);
        #2;
        rst_n = 1'b0;
        sb_q.delete();
        last_prod = '0;
        #1;
        check("arst_product", product, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_count", count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        directed("post_rst_u2x2", 1'b0, 4'd2, 4'd2, 8'd4);
        drain();

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected finish before %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
